sysreg_mgmt_master: RTL and testbench
=====================================

// Module: sysreg_mgmt_master
// PURPOSE
//  Core-side master for the management bus. Takes one sysreg read/write from the pipeline SRU and drives
//  mgmt_req/adr/rwn/wen/txd to all mgmt slaves (sysreg file, memory controller, peripherals).
//  Waits for mgmt_ack/mgmt_rxe or a timeout, then returns read data and error status to the pipeline.
//  Enforces the bus rule of one transaction at a time with one idle cycle between requests.
// PARAMETERS
//  TMO_CYCLES  15  cycles mgmt_req stays high without ack before abort; legal range 4..255
//  TMO_W       8   width of the timeout counter
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, asynchronous, active-high
//  cmd_valid   in   1   SRU command present
//  cmd_ready   out  1   command accepted when cmd_valid && cmd_ready
//  cmd_rwn     in   1   1 = read, 0 = write
//  cmd_wen     in   2   write byte-lane enables, passed through to mgmt_wen
//  cmd_adr     in   32  register address
//  cmd_wdata   in   32  write data
//  rsp_valid   out  1   one-cycle pulse; transaction finished
//  rsp_rdata   out  32  read data, valid with rsp_valid, otherwise 0
//  rsp_err     out  1   timeout abort, valid with rsp_valid
//  perf_sru    out  1   one-cycle pulse per accepted command; feeds perf[7]
//  mgmt_req    out  1   bus request, held until ack or timeout
//  mgmt_adr    out  32  address, stable while mgmt_req
//  mgmt_rwn    out  1   read/write, stable while mgmt_req
//  mgmt_wen    out  2   lane enables, stable while mgmt_req
//  mgmt_txd    out  32  write data, stable while mgmt_req
//  mgmt_ack    in   1   slave accepted; OR of all slaves
//  mgmt_rxe    in   1   read data valid; coincides with mgmt_ack on reads
//  mgmt_rxd    in   32  read data; OR of all slaves, 0 when not driven
// BEHAVIOUR
//  - Reset values: all outputs 0, state IDLE, counter 0, command registers 0; cmd_ready = 1 after reset release.
//  - FSM states:
//    - IDLE: cmd_ready = 1. On accept, latch rwn/wen/adr/wdata, pulse perf_sru, go to REQ.
//    - REQ: mgmt_req = 1 with the latched fields. Counter increments each cycle.
//      On mgmt_ack: capture rdata (below), go to GAP.
//      Else, when counter == TMO_CYCLES-1: set err, rdata = 0, go to GAP.
//    - GAP: mgmt_req = 0 and cmd_ready = 0. rsp_valid pulses with the captured rdata/err. Next state IDLE.
//  - cmd_ready = (state == IDLE). There is no command queueing.
//  - Latency for a normally responding slave (slave samples req, ack two cycles later):
//    - accept at cycle 0; req high cycles 1..3; ack in cycle 3; rsp_valid in cycle 4.
//    - next accept is possible in cycle 5, so the bus sees at least one idle cycle between requests.
//  - Read-data capture on ack:
//    - rwn = 1 and mgmt_rxe = 1: rdata = mgmt_rxd.
//    - rwn = 1 and mgmt_rxe = 0: rdata = 0, err = 0.
//    - write: rdata = 0.
//  - mgmt_ack/mgmt_rxe are ignored outside REQ; a late ack after a timeout is dropped.
//  - An ack in the same cycle the timeout is reached wins: response is normal, err = 0.
//  - Counter clears on entry to REQ and saturates; it never wraps.
//  - Mgmt output fields hold their last values when idle; only mgmt_req qualifies them.
//  - Asynchronous reset mid-transaction: req drops immediately and no rsp_valid is issued.
//    The pipeline flushes the SRU on reset.
// CONFIGURATION
//  Macro MGMT_TIMEOUT_EN:
//  - Defined: timeout counter and rsp_err behave as above.
//  - Undefined: no counter is built, REQ waits for mgmt_ack indefinitely, and rsp_err is tied to 0.
// STRUCTURE
//  - defines.v holds:
//    - FSM encodings MGMT_ST_IDLE/REQ/GAP (2 bits);
//    - default TMO_CYCLES;
//    - the shared mgmt address constants (ADDR_REG/MASK_REG) used by the bench.
//  - No sub-module; FSM, capture registers and counter are inline (~150 lines).
// TESTING
//  1. Read of sysreg MSTK: cmd adr=ADDR_REG|MSTK, rwn=1; slave acks cycle 3 with rxe=1, rxd=32'h0000_1234
//     -> rsp_valid cycle 4, rdata=32'h1234, err=0, perf_sru pulsed cycle 0.
//  2. Write to MVEC: wdata=32'h8000_0100, wen=2'b11 -> mgmt fields stable for all req cycles;
//     rsp_valid with rdata=0, err=0; cmd_ready low cycles 1..4.
//  3. Unmapped address, no slave acks (MGMT_TIMEOUT_EN defined) -> req high exactly 15 cycles;
//     rsp_valid with err=1, rdata=0; a stray ack two cycles later changes nothing.
//  4. Back-to-back: cmd_valid held high for 3 commands -> each request separated by at least one req-low cycle;
//     3 rsp pulses in order; 3 perf_sru pulses.
//  5. Ack with rwn=1 and rxe=0 -> rdata=0, err=0.
//     Ack coinciding with the timeout cycle -> err=0.
//  6. Assert rst during REQ -> mgmt_req=0 asynchronously; no rsp_valid; after release cmd_ready=1 and a new read
//     completes normally. Rebuild without MGMT_TIMEOUT_EN -> no-ack case holds req indefinitely (check 1000 cycles),
//     rsp_err never 1.

Source files
------------

// File: rtl/sysreg_mgmt_master_pkg.sv
// Shared definitions for the management-bus master: FSM encodings, the
// default timeout, and the mgmt address map constants used by SRU users.
package sysreg_mgmt_master_pkg;

  typedef enum logic [1:0] {
    MGMT_ST_IDLE = 2'd0,
    MGMT_ST_REQ  = 2'd1,
    MGMT_ST_GAP  = 2'd2
  } mgmt_st_t;

  localparam int TMO_CYCLES_DEF = 15;
  localparam int TMO_W_DEF      = 8;

  // Sysreg window on the mgmt bus and the mask selecting it.
  localparam logic [31:0] ADDR_REG = 32'hF000_0000;
  localparam logic [31:0] MASK_REG = 32'hFFFF_F000;

  // Register offsets inside the sysreg window.
  localparam logic [31:0] REG_MSTK = 32'h0000_0010;
  localparam logic [31:0] REG_MVEC = 32'h0000_0020;

endpackage

// File: rtl/sysreg_mgmt_master.sv
// Core-side management bus master. Takes one sysreg read/write from the SRU,
// holds mgmt_req with the latched command until a slave acks (or the request
// times out), then returns one rsp_valid pulse. A GAP cycle after every
// transaction guarantees a req-low cycle between requests on the bus.
//
// Build option: define MGMT_TIMEOUT_EN to build the timeout counter and
// rsp_err. Without it REQ waits for mgmt_ack forever and rsp_err is 0.
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, so there is no queueing. rsp_valid is a
// one-cycle pulse with no back-pressure; rsp_rdata/rsp_err are 0 outside it.
module sysreg_mgmt_master
  import sysreg_mgmt_master_pkg::*;
#(
  parameter int TMO_CYCLES = TMO_CYCLES_DEF,
  parameter int TMO_W      = TMO_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rwn,
  input  logic [1:0]  cmd_wen,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        perf_sru,
  output logic        mgmt_req,
  output logic [31:0] mgmt_adr,
  output logic        mgmt_rwn,
  output logic [1:0]  mgmt_wen,
  output logic [31:0] mgmt_txd,
  input  logic        mgmt_ack,
  input  logic        mgmt_rxe,
  input  logic [31:0] mgmt_rxd,
  output logic [1:0]  dbg_state
);

  // Reject timeouts the counter cannot represent or the bus cannot use.
  if (TMO_CYCLES < 4 || TMO_CYCLES > 255 || TMO_CYCLES > (1 << TMO_W)) begin : g_bad_tmo
    $error("sysreg_mgmt_master: TMO_CYCLES outside 4..255 or wider than TMO_W");
  end

  mgmt_st_t    state_q, state_d;
  logic        accept;
  logic        cap_en;
  logic [31:0] rdata_d;
  logic        rwn_q;
  logic [1:0]  wen_q;
  logic [31:0] adr_q, wdata_q, rdata_q;

`ifdef MGMT_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q;
  logic             tmo_hit;
  logic             err_d, err_q;
`endif

  // cmd_ready is forced low while reset is asserted so every output reads 0.
  assign cmd_ready = (state_q == MGMT_ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign perf_sru  = accept;

  assign mgmt_req  = (state_q == MGMT_ST_REQ);
  assign mgmt_adr  = adr_q;
  assign mgmt_rwn  = rwn_q;
  assign mgmt_wen  = wen_q;
  assign mgmt_txd  = wdata_q;

  assign rsp_valid = (state_q == MGMT_ST_GAP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign dbg_state = state_q;

`ifdef MGMT_TIMEOUT_EN
  assign tmo_hit = (cnt_q == TMO_W'(TMO_CYCLES - 1));
  assign rsp_err = rsp_valid && err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // State register; async reset drops mgmt_req immediately mid-transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MGMT_ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and response capture; an ack in the timeout cycle wins.
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    rdata_d = 32'h0;
`ifdef MGMT_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      MGMT_ST_IDLE: begin
        if (accept) state_d = MGMT_ST_REQ;
      end
      MGMT_ST_REQ: begin
        if (mgmt_ack) begin
          state_d = MGMT_ST_GAP;
          cap_en  = 1'b1;
          rdata_d = (rwn_q && mgmt_rxe) ? mgmt_rxd : 32'h0;
        end
`ifdef MGMT_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = MGMT_ST_GAP;
          cap_en  = 1'b1;
          err_d   = 1'b1;
        end
`endif
      end
      MGMT_ST_GAP: begin
        state_d = MGMT_ST_IDLE;
      end
      default: begin
        state_d = MGMT_ST_IDLE;
      end
    endcase
  end

  // Command fields latch on accept and hold afterwards; only mgmt_req qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rwn_q   <= 1'b0;
      wen_q   <= 2'b00;
      adr_q   <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      rwn_q   <= cmd_rwn;
      wen_q   <= cmd_wen;
      adr_q   <= cmd_adr;
      wdata_q <= cmd_wdata;
    end
  end

  // Read data is captured when REQ ends and presented during GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata_q <= 32'h0;
    else if (cap_en) rdata_q <= rdata_d;
  end

`ifdef MGMT_TIMEOUT_EN
  // Request-age counter: cleared on accept, counts REQ cycles, saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              cnt_q <= '0;
    else if (accept)                                      cnt_q <= '0;
    else if (state_q == MGMT_ST_REQ && cnt_q != {TMO_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
  end

  // Error flag captured alongside read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (cap_en) err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_sysreg_mgmt_master.sv
// Directed bench for sysreg_mgmt_master. Inputs are driven 1 ns after the
// rising edge, outputs are sampled on the falling edge.
module tb_sysreg_mgmt_master;
  import sysreg_mgmt_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rwn = 1'b0;
  logic [1:0]  cmd_wen = 2'b00;
  logic [31:0] cmd_adr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        perf_sru;
  logic        mgmt_req;
  logic [31:0] mgmt_adr;
  logic        mgmt_rwn;
  logic [1:0]  mgmt_wen;
  logic [31:0] mgmt_txd;
  logic        mgmt_ack = 1'b0;
  logic        mgmt_rxe = 1'b0;
  logic [31:0] mgmt_rxd = 32'h0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  sysreg_mgmt_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rwn(cmd_rwn),
    .cmd_wen(cmd_wen), .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .perf_sru(perf_sru),
    .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_rwn(mgmt_rwn),
    .mgmt_wen(mgmt_wen), .mgmt_txd(mgmt_txd),
    .mgmt_ack(mgmt_ack), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command from accept (cycle 0) to rsp_valid; the slave acks in ack_cyc (-1 = never).
  task automatic do_txn(input string tag, input logic rwn, input logic [1:0] wen,
                        input logic [31:0] adr, input logic [31:0] wdata,
                        input int ack_cyc, input logic rxe, input logic [31:0] rxd,
                        input int budget,
                        output int req_n, output int rsp_cyc, output logic [31:0] rdata,
                        output logic err, output int ready_low, output int bad_fields,
                        output int err_seen);
    req_n = 0; rsp_cyc = -1; rdata = 32'h0; err = 1'b0;
    ready_low = 0; bad_fields = 0; err_seen = 0;
    step();
    cmd_valid = 1'b1; cmd_rwn = rwn; cmd_wen = wen; cmd_adr = adr; cmd_wdata = wdata;
    @(negedge clk);
    check({tag, "_ready0"}, 32'(cmd_ready), 32'd1);
    check({tag, "_perf0"}, 32'(perf_sru), 32'd1);
    for (int c = 1; c <= budget; c++) begin
      step();
      cmd_valid = 1'b0; cmd_rwn = ~rwn; cmd_wen = ~wen; cmd_adr = ~adr; cmd_wdata = ~wdata;
      mgmt_ack = (c == ack_cyc);
      mgmt_rxe = (c == ack_cyc) && rxe;
      mgmt_rxd = (c == ack_cyc) ? rxd : 32'h0;
      @(negedge clk);
      if (mgmt_req) begin
        req_n++;
        if (mgmt_adr !== adr || mgmt_rwn !== rwn || mgmt_wen !== wen || mgmt_txd !== wdata)
          bad_fields++;
      end
      if (!cmd_ready) ready_low++;
      if (rsp_err) err_seen++;
      if (rsp_valid) begin
        rsp_cyc = c; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    step();
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = 32'h0;
  endtask

  // Assert reset away from a clock edge while a request is outstanding.
  task automatic reset_in_req(input string tag);
    @(negedge clk);
    check({tag, "_req_before"}, 32'(mgmt_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check({tag, "_req_async"}, 32'(mgmt_req), 32'd0);
    check({tag, "_rsp_in_rst"}, 32'(rsp_valid), 32'd0);
    check({tag, "_state_in_rst"}, 32'(dbg_state), 32'd0);
    check({tag, "_adr_in_rst"}, mgmt_adr, 32'h0);
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rsp_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int          req_n, rsp_cyc, ready_low, bad_fields, err_seen;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] b2b_adr[3];
    int          idx, rises, perf_n, rsp_n, last_rsp, req_run, rd_leak;
    logic        prev_req, accepted;
    logic [31:0] exp_v;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_req", 32'(mgmt_req), 32'd0);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    check("rst_perf", 32'(perf_sru), 32'd0);
    check("rst_adr", mgmt_adr, 32'h0);
    check("rst_txd", mgmt_txd, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(MGMT_ST_IDLE));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(cmd_ready), 32'd1);
    check("rel_rdata", rsp_rdata, 32'h0);

    // 1: read MSTK, ack in cycle 3 with data
    do_txn("rd", 1'b1, 2'b00, ADDR_REG | REG_MSTK, 32'h0, 3, 1'b1, 32'h0000_1234, 40,
           req_n, rsp_cyc, rdata, err, ready_low, bad_fields, err_seen);
    check("rd_req_n", 32'(req_n), 32'd3);
    check("rd_rsp_cyc", 32'(rsp_cyc), 32'd4);
    check("rd_rdata", rdata, 32'h0000_1234);
    check("rd_err", 32'(err), 32'd0);
    check("rd_fields", 32'(bad_fields), 32'd0);
    @(negedge clk);
    check("rd_ready_c5", 32'(cmd_ready), 32'd1);
    check("rd_rdata_idle", rsp_rdata, 32'h0);

    // 2: write MVEC; slave raises rxe with junk data which must not appear
    do_txn("wr", 1'b0, 2'b11, ADDR_REG | REG_MVEC, 32'h8000_0100, 3, 1'b1, 32'hCAFE_F00D, 40,
           req_n, rsp_cyc, rdata, err, ready_low, bad_fields, err_seen);
    check("wr_req_n", 32'(req_n), 32'd3);
    check("wr_rsp_cyc", 32'(rsp_cyc), 32'd4);
    check("wr_rdata", rdata, 32'h0);
    check("wr_err", 32'(err), 32'd0);
    check("wr_fields", 32'(bad_fields), 32'd0);
    check("wr_ready_low", 32'(ready_low), 32'd4);

    // 5a: read acked without rxe returns zero data, no error
    do_txn("norxe", 1'b1, 2'b00, ADDR_REG | REG_MSTK, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 40,
           req_n, rsp_cyc, rdata, err, ready_low, bad_fields, err_seen);
    check("norxe_rsp_cyc", 32'(rsp_cyc), 32'd4);
    check("norxe_rdata", rdata, 32'h0);
    check("norxe_err", 32'(err), 32'd0);

    // 4: back-to-back reads with cmd_valid held high
    b2b_adr[0] = ADDR_REG | 32'h0000_0100;
    b2b_adr[1] = ADDR_REG | 32'h0000_0204;
    b2b_adr[2] = ADDR_REG | 32'h0000_0308;
    idx = 0; rises = 0; perf_n = 0; rsp_n = 0; last_rsp = -1; req_run = 0; rd_leak = 0;
    prev_req = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_rwn = 1'b1; cmd_wen = 2'b00; cmd_adr = b2b_adr[0]; cmd_wdata = 32'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      accepted = cmd_valid && cmd_ready;
      if (perf_sru) perf_n++;
      if (accepted) exp_q.push_back(b2b_adr[idx] ^ 32'h00A5_0000);
      if (mgmt_req && !prev_req) rises++;
      prev_req = mgmt_req;
      req_run = mgmt_req ? req_run + 1 : 0;
      if (!rsp_valid && rsp_rdata != 32'h0) rd_leak++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("b2b_rdata", rsp_rdata, exp_v);
        end
        rsp_n++;
        last_rsp = c;
      end
      step();
      if (accepted) idx++;
      if (idx < 3) cmd_adr = b2b_adr[idx];
      else cmd_valid = 1'b0;
      mgmt_ack = (req_run == 2);
      mgmt_rxe = (req_run == 2);
      mgmt_rxd = (req_run == 2) ? (mgmt_adr ^ 32'h00A5_0000) : 32'h0;
      if (rsp_n == 3) break;
    end
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = 32'h0;
    check("b2b_rises", 32'(rises), 32'd3);
    check("b2b_perf", 32'(perf_n), 32'd3);
    check("b2b_rsp_n", 32'(rsp_n), 32'd3);
    check("b2b_last_rsp", 32'(last_rsp), 32'd14);
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);
    check("b2b_rdata_leak", 32'(rd_leak), 32'd0);

`ifdef MGMT_TIMEOUT_EN
    // 3: unmapped address, nobody acks
    do_txn("tmo", 1'b1, 2'b00, 32'h0BAD_0000, 32'h0, -1, 1'b0, 32'h0, 40,
           req_n, rsp_cyc, rdata, err, ready_low, bad_fields, err_seen);
    check("tmo_req_n", 32'(req_n), 32'd15);
    check("tmo_rsp_cyc", 32'(rsp_cyc), 32'd16);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_rdata", rdata, 32'h0);
    @(negedge clk);
    check("tmo_ready", 32'(cmd_ready), 32'd1);
    check("tmo_err_idle", 32'(rsp_err), 32'd0);
    // stray late ack two cycles after the response
    step();
    mgmt_ack = 1'b1; mgmt_rxe = 1'b1; mgmt_rxd = 32'hFFFF_FFFF;
    @(negedge clk);
    check("late_ack_req", 32'(mgmt_req), 32'd0);
    check("late_ack_rsp", 32'(rsp_valid), 32'd0);
    check("late_ack_state", 32'(dbg_state), 32'(MGMT_ST_IDLE));
    step();
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = 32'h0;
    @(negedge clk);
    check("late_ack_rsp2", 32'(rsp_valid), 32'd0);

    // 5b: ack in the same cycle the timeout is reached wins
    do_txn("ackedge", 1'b1, 2'b00, ADDR_REG | REG_MSTK, 32'h0, 15, 1'b1, 32'h0000_5A5A, 40,
           req_n, rsp_cyc, rdata, err, ready_low, bad_fields, err_seen);
    check("ackedge_req_n", 32'(req_n), 32'd15);
    check("ackedge_rsp_cyc", 32'(rsp_cyc), 32'd16);
    check("ackedge_err", 32'(err), 32'd0);
    check("ackedge_rdata", rdata, 32'h0000_5A5A);
`else
    // Without the timeout a missing ack holds the request indefinitely
    do_txn("hold", 1'b1, 2'b00, 32'h0BAD_0000, 32'h0, -1, 1'b0, 32'h0, 1000,
           req_n, rsp_cyc, rdata, err, ready_low, bad_fields, err_seen);
    check("hold_req_n", 32'(req_n), 32'd1000);
    check("hold_no_rsp", 32'(rsp_cyc), 32'hFFFF_FFFF);
    check("hold_err_seen", 32'(err_seen), 32'd0);
    reset_in_req("hold_rst");
`endif

    // 6: reset in the middle of a request, then a normal read
    step();
    cmd_valid = 1'b1; cmd_rwn = 1'b1; cmd_wen = 2'b00; cmd_adr = ADDR_REG | REG_MSTK;
    step();
    cmd_valid = 1'b0;
    reset_in_req("midrst");
    do_txn("postrst", 1'b1, 2'b00, ADDR_REG | REG_MSTK, 32'h0, 3, 1'b1, 32'h0000_0777, 40,
           req_n, rsp_cyc, rdata, err, ready_low, bad_fields, err_seen);
    check("postrst_rsp_cyc", 32'(rsp_cyc), 32'd4);
    check("postrst_rdata", rdata, 32'h0000_0777);
    check("postrst_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
